// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with a hold-time limit.
// One owner at a time. Ownership hands off with no idle cycle between owners.
// An owner is forced to release after HOLD_MAX cycles, which bounds how long
// any continuously-requesting master can be starved.
module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    last;
  logic [1:0]    last_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    sel_nxt;
  logic          busy_nxt;
  logic          timeout_nxt;

  logic          owner_req_c;
  logic          hold_hit_c;
  logic          release_c;
  logic [2:0]    pick_idle_c;
  logic [2:0]    pick_rel_c;

  // Priority pick: the first set bit of r, searching upward from index s and
  // wrapping. Bit 2 of the result is the found flag and bits 1:0 are the index.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] s);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {r, r};
    rot = dbl[s +: 4];
    if (rot[0])      rr_pick = {1'b1, s};
    else if (rot[1]) rr_pick = {1'b1, 2'(s + 2'd1)};
    else if (rot[2]) rr_pick = {1'b1, 2'(s + 2'd2)};
    else if (rot[3]) rr_pick = {1'b1, 2'(s + 2'd3)};
    else             rr_pick = 3'b000;
  endfunction

  // Release conditions and candidate picks. While in OWN, sel holds the owner.
  always_comb begin
    owner_req_c = req[sel];
    hold_hit_c  = (cnt == CNT_LAST);
    release_c   = done | ~owner_req_c | hold_hit_c;
    pick_idle_c = rr_pick(req, 2'(last + 2'd1));
    pick_rel_c  = rr_pick(req & ~(4'b0001 << sel), 2'(sel + 2'd1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    cnt_nxt     = cnt;
    sel_nxt     = sel;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (pick_idle_c[2]) begin
          state_nxt = OWN;
          sel_nxt   = pick_idle_c[1:0];
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (!release_c) begin
          cnt_nxt = CW'(cnt + 1'b1);
        end else begin
          last_nxt    = sel;
          timeout_nxt = hold_hit_c & ~done & owner_req_c;
          cnt_nxt     = '0;
          if (pick_rel_c[2]) begin
            sel_nxt = pick_rel_c[1:0];
          end else if (!owner_req_c) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == OWN);
    gnt_nxt  = busy_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
  end

  // State, bookkeeping and registered outputs. Reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'd3;
      cnt     <= '0;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      sel     <= sel_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Testbench for rr_arb4: table vectors, directed corner sequences, and
// random traffic checked against a behavioral scoreboard model.
module tb_rr_arb4;

  localparam int unsigned HOLD   = 16;
  localparam int unsigned STARVE = 3 * HOLD + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  rr_arb4 #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } obs_t;

  typedef struct {
    bit         r;
    logic [3:0] rq;
    bit         d;
    logic [3:0] g;
    logic [1:0] s;
    bit         b;
  } vec_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   waitc[4] = '{0, 0, 0, 0};

  // Behavioral reference state
  bit m_own   = 1'b0;
  int m_owner = 0;
  int m_last  = 3;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] rq, input bit d);
    bit hold;
    bit rel;
    bit found;
    int old;
    int idx;
    if (r) begin
      m_own = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_to = 0;
    end else if (!m_own) begin
      m_to  = 0;
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (!found && rq[idx]) begin
          found = 1; m_own = 1; m_owner = idx; m_cnt = 0;
        end
      end
    end else begin
      old  = m_owner;
      hold = (m_cnt == HOLD - 1);
      rel  = d || !rq[old] || hold;
      m_to = hold && !d && rq[old];
      if (!rel) begin
        m_cnt++;
      end else begin
        m_last = old;
        found  = 0;
        for (int k = 1; k <= 3; k++) begin
          idx = (old + k) % 4;
          if (!found && rq[idx]) begin
            found = 1; m_owner = idx;
          end
        end
        m_cnt = 0;
        if (!found && !rq[old]) m_own = 0;
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.g = m_own ? 4'(1 << m_owner) : 4'b0000;
    o.s = 2'(m_owner);
    o.b = m_own;
    o.t = m_to;
    return o;
  endfunction

  // One clock: drive inputs, queue the prediction, sample after the edge, compare.
  task automatic cyc(input bit r, input logic [3:0] rq, input bit d);
    obs_t e;
    obs_t a;
    rst = r; req = rq; done = d;
    model_step(r, rq, d);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    a = {gnt, sel, busy, timeout};
    e = sb_q.pop_front();
    check("scoreboard", 32'(a), 32'(e));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("busy_gnt", 32'(busy), 32'(gnt != 4'b0000));
    if (busy) check("sel_gnt", 32'(gnt), 32'(4'b0001 << sel));
    for (int i = 0; i < 4; i++) begin
      if (!r && rq[i] && !gnt[i]) waitc[i]++;
      else waitc[i] = 0;
      check("starve", 32'(waitc[i] <= STARVE), 32'd1);
    end
  endtask

  vec_t vt[12];

  initial begin
    logic [3:0] rq;
    bit         d;

    rst = 1'b1; req = 4'b0000; done = 1'b0;

    // Rotation through all four owners, owner drop, non-owner changes, idle.
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vt[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vt[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vt[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    vt[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vt[7]  = '{1'b0, 4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[8]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
    vt[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
    vt[11] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};

    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].r, vt[i].rq, vt[i].d);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].g));
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].s));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].b));
    end

    // Hold limit: forced release and re-grant every HOLD cycles.
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    check("hold_first_gnt", 32'(gnt), 32'(4'b0100));
    for (int j = 1; j <= 32; j++) begin
      cyc(1'b0, 4'b0100, 1'b0);
      check($sformatf("hold%0d_gnt", j), 32'(gnt), 32'(4'b0100));
      check($sformatf("hold%0d_to", j), 32'(timeout), 32'(j == 16 || j == 32));
    end

    // Owner 1 drops its request: index 3 wins over 0 with no idle cycle.
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b1011, 1'b0);
    check("drop_hold_gnt", 32'(gnt), 32'(4'b0010));
    cyc(1'b0, 4'b1001, 1'b0);
    check("drop_next_gnt", 32'(gnt), 32'(4'b1000));
    check("drop_next_sel", 32'(sel), 32'd3);

    // Done with sole requester re-grants; done with no requests goes idle.
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b1);
    check("regrant_gnt", 32'(gnt), 32'(4'b0100));
    check("regrant_to", 32'(timeout), 32'd0);
    cyc(1'b0, 4'b0000, 1'b1);
    check("done_idle_gnt", 32'(gnt), 32'd0);
    check("done_idle_busy", 32'(busy), 32'd0);
    check("done_idle_sel", 32'(sel), 32'd2);

    // Reset while owner 3 active: priority returns to requester 0.
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1000, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    check("pre_rst_gnt", 32'(gnt), 32'(4'b1000));
    cyc(1'b1, 4'b1001, 1'b1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    cyc(1'b0, 4'b1001, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'(4'b0001));

    // Random traffic against the scoreboard and invariants.
    cyc(1'b1, 4'b0000, 1'b0);
    rq = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(15) == 0) rq[b] = ~rq[b];
      end
      d = ($urandom_range(5) == 0);
      cyc(1'b0, rq, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
